// File: rtl/snake_pkg.sv
// Shared grid geometry, coordinate type and food-placer state encoding
// used by the snake game blocks.
package snake_pkg;

  localparam int GRID_W  = 40;
  localparam int GRID_H  = 30;
  localparam int COORD_W = 6;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    QUERY,
    SCAN,
    DONE,
    FAIL
  } fp_state_t;

endpackage

// File: rtl/food_scan_ctr.sv
// Wrap-around raster counter over a W x H grid with load, single-step
// advance and a flag marking the final cell of a full sweep.
module food_scan_ctr #(
  parameter int W  = 40,
  parameter int H  = 30,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_x,
  input  logic [CW-1:0] load_y,
  input  logic          step,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          sweep_done
);

  localparam int NCELL = W * H;
  localparam int CNT_W = $clog2(NCELL);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      x   <= '0;
      y   <= '0;
      cnt <= '0;
    end else if (load) begin
      x   <= load_x;
      y   <= load_y;
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (x == CW'(W - 1)) begin
        x <= '0;
        y <= (y == CW'(H - 1)) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // High while the current cell is the last one of a sweep started at load.
  assign sweep_done = (cnt == CNT_W'(NCELL - 1));

endmodule

// File: rtl/food_placer.sv
// Picks a free grid cell for new food from the rng word, retrying via the
// occupancy handshake. FOOD_SCAN_FALLBACK_EN adds a raster-scan fallback.
module food_placer #(
  parameter int GRID_W    = snake_pkg::GRID_W,
  parameter int GRID_H    = snake_pkg::GRID_H,
  parameter int COORD_W   = snake_pkg::COORD_W,
  parameter int MAX_TRIES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [14:0]        rnd,
  input  logic               req,
  output logic               occ_req,
  output logic [COORD_W-1:0] occ_x,
  output logic [COORD_W-1:0] occ_y,
  input  logic               occ_ack,
  input  logic               occ_hit,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               busy,
  output logic               fail
);
  import snake_pkg::*;

  localparam int TW = $clog2(MAX_TRIES + 1);

  fp_state_t          state;
  logic [TW-1:0]      tries;
  logic [14:0]        last;
  logic               first;
  logic [COORD_W-1:0] cx, cy;
  logic               in_range, fresh, limit;

  assign cx       = rnd[COORD_W-1:0];
  assign cy       = rnd[2*COORD_W-1:COORD_W];
  assign in_range = ({1'b0, cx} < (COORD_W + 1)'(GRID_W)) &&
                    ({1'b0, cy} < (COORD_W + 1)'(GRID_H));
  assign fresh    = first || (rnd != last);
  assign limit    = (tries == TW'(MAX_TRIES - 1));

`ifdef FOOD_SCAN_FALLBACK_EN
  localparam fp_state_t LIMIT_ST = SCAN;

  logic               scan_run, scan_load, scan_step, sweep_done;
  logic [COORD_W-1:0] sx, sy, cand_x, cand_y;

  // First SCAN cycle loads the raster counter; a hit on a non-final cell steps it.
  always_comb begin
    scan_load = (state == SCAN) && !scan_run;
    scan_step = (state == SCAN) && scan_run && occ_req && occ_ack &&
                occ_hit && !sweep_done;
  end

  food_scan_ctr #(.W(GRID_W), .H(GRID_H), .CW(COORD_W)) u_scan (
    .clk        (clk),
    .rst        (rst),
    .load       (scan_load),
    .load_x     (cand_x),
    .load_y     (cand_y),
    .step       (scan_step),
    .x          (sx),
    .y          (sy),
    .sweep_done (sweep_done)
  );
`else
  localparam fp_state_t LIMIT_ST = FAIL;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tries      <= '0;
      last       <= '0;
      first      <= 1'b0;
      occ_req    <= 1'b0;
      occ_x      <= '0;
      occ_y      <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      busy       <= 1'b0;
      fail       <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
      scan_run   <= 1'b0;
      cand_x     <= '0;
      cand_y     <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (req) begin
            state      <= SAMPLE;
            food_valid <= 1'b0;
            fail       <= 1'b0;
            tries      <= '0;
            busy       <= 1'b1;
            first      <= 1'b1;
          end
        end
        SAMPLE: if (fresh) begin
          last  <= rnd;
          first <= 1'b0;
          if (in_range) begin
            occ_x   <= cx;
            occ_y   <= cy;
            occ_req <= 1'b1;
            state   <= QUERY;
`ifdef FOOD_SCAN_FALLBACK_EN
            cand_x  <= cx;
            cand_y  <= cy;
`endif
          end else begin
            tries <= tries + 1'b1;
            if (limit) state <= LIMIT_ST;
          end
        end
        QUERY: if (occ_ack) begin
          occ_req <= 1'b0;
          if (!occ_hit) begin
            food_x     <= occ_x;
            food_y     <= occ_y;
            food_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end else begin
            tries <= tries + 1'b1;
            state <= limit ? LIMIT_ST : SAMPLE;
          end
        end
`ifdef FOOD_SCAN_FALLBACK_EN
        SCAN: begin
          if (!scan_run) begin
            scan_run <= 1'b1;
          end else if (!occ_req) begin
            occ_req <= 1'b1;
            occ_x   <= sx;
            occ_y   <= sy;
          end else if (occ_ack) begin
            occ_req <= 1'b0;
            if (!occ_hit) begin
              food_x     <= occ_x;
              food_y     <= occ_y;
              food_valid <= 1'b1;
              busy       <= 1'b0;
              scan_run   <= 1'b0;
              state      <= DONE;
            end else if (sweep_done) begin
              scan_run <= 1'b0;
              state    <= FAIL;
            end
          end
        end
`endif
        FAIL: begin
          fail       <= 1'b1;
          busy       <= 1'b0;
          food_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/food_placer.md
Name: food_placer

Overview:
- Consumes the 15-bit LFSR word from rng and produces a free grid cell for the next food item.
- Slices the random word into candidate (x,y) and rejects out-of-range candidates.
- Queries the snake-body occupancy logic over a one-outstanding request/response handshake; retries until a free cell is found.
- Sits between rng and the game-state/draw controller.

Parameters:
- GRID_W, 40, grid columns (must be ≤ 2^COORD_W).
- GRID_H, 30, grid rows (must be ≤ 2^COORD_W).
- COORD_W, 6, coordinate width in bits.
- MAX_TRIES, 64, rejected/occupied candidates allowed before giving up; counter width $clog2(MAX_TRIES+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- rnd  in  15  random word from rng.
- req  in  1  one-cycle pulse: place new food.
- occ_req  out  1  occupancy query valid.
- occ_x  out  COORD_W  queried column.
- occ_y  out  COORD_W  queried row.
- occ_ack  in  1  response valid, at least 1 cycle after occ_req.
- occ_hit  in  1  cell is occupied; qualified by occ_ack.
- food_x  out  COORD_W  placed column.
- food_y  out  COORD_W  placed row.
- food_valid  out  1  level: food_x/food_y hold a placed cell.
- busy  out  1  placement in progress.
- fail  out  1  level: placement gave up.

Behaviour:
- Reset: clk edge with rst=0. State IDLE; all outputs 0, including food_x, food_y, occ_x, occ_y. Try counter and last-sample register cleared. Reset mid-placement aborts; no occ_req issued afterwards.
- Candidate: cx = rnd[COORD_W-1:0], cy = rnd[2*COORD_W-1:COORD_W]; bits above are ignored.
- Fresh-sample rule: rng updates only every 16 clocks. A candidate is taken only when rnd differs from the last sampled word. The first sample after req accepts any value.
- IDLE:
  - req=1 → SAMPLE; clear food_valid, fail, try counter; set busy.
  - req is ignored while busy=1.
- SAMPLE: waits for a fresh rnd, then latches it.
  - cx ≥ GRID_W or cy ≥ GRID_H: try counter +1; stay in SAMPLE.
  - Otherwise: drive occ_x/occ_y, assert occ_req → QUERY.
- QUERY: occ_req held high until occ_ack; occ_req, occ_x, occ_y change only in the cycle after occ_ack.
  - occ_ack & !occ_hit → DONE.
  - occ_ack & occ_hit → try counter +1; → SAMPLE.
  - occ_ack in the same cycle occ_req rises is illegal; assertion in bench.
- Try limit: when the counter reaches MAX_TRIES → FAIL, or SCAN if the optional feature is compiled in.
- DONE (one cycle): food_x/food_y ← accepted candidate; food_valid=1; busy=0 → IDLE. Outputs hold until the next req.
- FAIL: fail=1, busy=0, food_valid=0 → IDLE. fail holds until the next req.
- Latency: 1 cycle from the rising edge of fresh rnd to occ_req; 1 cycle from a free occ_ack to food_valid.

Optional Feature:
- Macro FOOD_SCAN_FALLBACK_EN.
- Defined: on try limit, enter SCAN.
  - Starting from the last in-range candidate (or 0,0), step x+1 and wrap to 0 with y+1; y wraps at GRID_H.
  - Query each cell with the same handshake; the first free cell → DONE.
  - A full GRID_W*GRID_H sweep with every cell occupied → FAIL.
- Undefined: try limit goes straight to FAIL; no SCAN state exists.

Decomposition:
- Shared package snake_pkg: GRID_W, GRID_H, COORD_W constants; coord_t typedef; state enum fp_state_t {IDLE, SAMPLE, QUERY, SCAN, DONE, FAIL}.
- One sub-module, food_scan_ctr: wrap-around x/y raster counter with load, step and sweep-complete flag. It is reused by the draw logic.

Test Plan:
- rnd fixed 15'h0A85 (cx=5, cy=42 ≥ 30), then 15'h0285 (cx=5, cy=10), occupancy always free → one occ_req at (5,10); food_x=5, food_y=10, food_valid=1 one cycle after occ_ack.
- rnd held constant after the first sample → no second occ_req issued.
- Occupancy reports hit for (5,10), free for the next fresh candidate (7,3) → food=(7,3), try counter=1.
- All cells occupied, macro undefined → fail=1 after exactly 64 tries, food_valid=0.
- Macro defined, only (0,0) free → SCAN wraps the grid; food=(0,0). With 0 free cells → fail after a 1200-cell sweep.
- rst=0 asserted while in QUERY → next cycle busy=0, occ_req=0, outputs 0; a req issued during busy is ignored.
